// File: rtl/add64_seq_if.sv
// Bundle of the request, result and external-adder signals of the sequential 64-bit adder.
// The slave side is the sequencer; the master side is its environment (upstream, consumer and adder).
interface add64_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_ci;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_ci;
   logic [31:0] add_s;
   logic        add_co;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_co;
   logic        out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_ci, add_s, add_co, out_ready,
      output in_ready, add_a, add_b, add_ci, out_valid, out_sum, out_co, out_ovf
   );

   modport master (
      output in_valid, in_a, in_b, in_ci, add_s, add_co, out_ready,
      input  in_ready, add_a, add_b, add_ci, out_valid, out_sum, out_co, out_ovf
   );
endinterface

// File: rtl/add64_seq.sv
// 64-bit add sequenced through an external registered 32-bit adder: low half, then high half
// with the low carry chained in, each half waiting LAT edges for the adder to settle.
module add64_seq #(
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   add64_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   // Signed overflow from the operand sign bits and the result sign bit.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_hi_q, a_hi_d;
   logic [31:0] b_hi_q, b_hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] add_a_q, add_a_d;
   logic [31:0] add_b_q, add_b_d;
   logic        add_ci_q, add_ci_d;
   logic [63:0] sum_q, sum_d;
   logic        co_q, co_d;
   logic        ovf_q, ovf_d;
   logic        in_ready_s;
   logic        out_valid_s;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.in_valid)    state_d = S_LO;   else state_d = S_IDLE;
         S_LO:    if (cnt_q == 4'd0)   state_d = S_HI;   else state_d = S_LO;
         S_HI:    if (cnt_q == 4'd0)   state_d = S_DONE; else state_d = S_HI;
         S_DONE:  if (bus.out_ready)   state_d = S_IDLE; else state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs; in_ready drops with reset_n without waiting for an edge.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_q)
         S_IDLE:  in_ready_s  = reset_n;
         S_DONE:  out_valid_s = 1'b1;
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Datapath next values: operand capture, half sequencing, result update.
   always_comb begin
      cnt_d    = cnt_q;
      a_hi_d   = a_hi_q;
      b_hi_d   = b_hi_q;
      lo_d     = lo_q;
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
      add_ci_d = add_ci_q;
      sum_d    = sum_q;
      co_d     = co_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_hi_d   = bus.in_a[63:32];
               b_hi_d   = bus.in_b[63:32];
               add_a_d  = bus.in_a[31:0];
               add_b_d  = bus.in_b[31:0];
               add_ci_d = bus.in_ci;
               cnt_d    = CNT_INIT;
            end else begin
               cnt_d    = cnt_q;
            end
         end
         S_LO: begin
            if (cnt_q != 4'd0) begin
               cnt_d    = cnt_q - 4'd1;
            end else begin
               lo_d     = bus.add_s;
               add_a_d  = a_hi_q;
               add_b_d  = b_hi_q;
               add_ci_d = bus.add_co;
               cnt_d    = CNT_INIT;
            end
         end
         S_HI: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               sum_d = {bus.add_s, lo_q};
               co_d  = bus.add_co;
               ovf_d = signed_ovf(a_hi_q[31], b_hi_q[31], bus.add_s[31]);
            end
         end
         S_DONE: begin
            cnt_d = cnt_q;
         end
         default: begin
            cnt_d = 4'd0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= 4'd0;
         a_hi_q   <= 32'd0;
         b_hi_q   <= 32'd0;
         lo_q     <= 32'd0;
         add_a_q  <= 32'd0;
         add_b_q  <= 32'd0;
         add_ci_q <= 1'b0;
         sum_q    <= 64'd0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         a_hi_q   <= a_hi_d;
         b_hi_q   <= b_hi_d;
         lo_q     <= lo_d;
         add_a_q  <= add_a_d;
         add_b_q  <= add_b_d;
         add_ci_q <= add_ci_d;
         sum_q    <= sum_d;
         co_q     <= co_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_ci    = add_ci_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_co    = co_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_add64_seq.sv
// Bench for add64_seq: LAT=1 and LAT=3 instances, each with its own external adder model,
// checked against a plain 65-bit arithmetic reference.
module tb_add64_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sel;
   logic        drv_valid;
   logic        drv_ci;
   logic        drv_oready;
   logic [63:0] drv_a;
   logic [63:0] drv_b;

   int n_chk  = 0;
   int n_pass = 0;

   logic [63:0] prev_sum [2];
   logic        prev_co  [2];
   logic        prev_ovf [2];

   add64_seq_if if1 ();
   add64_seq_if if3 ();

   add64_seq #(.LAT(1)) u_dut1 (.clk(clk), .reset_n(rst_n), .bus(if1.slave));
   add64_seq #(.LAT(3)) u_dut3 (.clk(clk), .reset_n(rst_n), .bus(if3.slave));

   assign if1.in_valid  = drv_valid & ~sel;
   assign if3.in_valid  = drv_valid & sel;
   assign if1.out_ready = drv_oready & ~sel;
   assign if3.out_ready = drv_oready & sel;
   assign if1.in_a  = drv_a;
   assign if3.in_a  = drv_a;
   assign if1.in_b  = drv_b;
   assign if3.in_b  = drv_b;
   assign if1.in_ci = drv_ci;
   assign if3.in_ci = drv_ci;

   // Adder with LAT=1: result settles before the next edge.
   assign {if1.add_co, if1.add_s} = {1'b0, if1.add_a} + {1'b0, if1.add_b} + {32'd0, if1.add_ci};

   // Adder with LAT=3: two register stages, so an early sample sees stale data.
   logic [32:0] p1_q, p2_q;
   always_ff @(posedge clk) begin
      p1_q <= {1'b0, if3.add_a} + {1'b0, if3.add_b} + {32'd0, if3.add_ci};
      p2_q <= p1_q;
   end
   assign {if3.add_co, if3.add_s} = p2_q;

   logic        mon_ready, mon_valid, mon_co, mon_ovf, mon_aci;
   logic [63:0] mon_sum;
   logic [31:0] mon_aa, mon_ab;
   assign mon_ready = sel ? if3.in_ready  : if1.in_ready;
   assign mon_valid = sel ? if3.out_valid : if1.out_valid;
   assign mon_co    = sel ? if3.out_co    : if1.out_co;
   assign mon_ovf   = sel ? if3.out_ovf   : if1.out_ovf;
   assign mon_sum   = sel ? if3.out_sum   : if1.out_sum;
   assign mon_aa    = sel ? if3.add_a     : if1.add_a;
   assign mon_ab    = sel ? if3.add_b     : if1.add_b;
   assign mon_aci   = sel ? if3.add_ci    : if1.add_ci;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s (sel=%0d t=%0t): got %h expected %h", tag, sel, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input logic [63:0] a, input logic [63:0] b, input logic ci, input int hold);
      int          lat, e, idx;
      logic [64:0] full;
      logic [32:0] lo;
      logic        eovf;
      idx  = sel ? 1 : 0;
      lat  = sel ? 3 : 1;
      full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
      lo   = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, ci};
      eovf = (a[63] == b[63]) && (full[63] != a[63]);

      drv_a = a; drv_b = b; drv_ci = ci; drv_valid = 1'b1; drv_oready = 1'b0;
      chk("idle_ready", 64'(mon_ready), 64'd1);
      tick();
      // Keep in_valid high with different operands: they must be ignored.
      drv_a = ~a; drv_b = {$urandom, $urandom}; drv_ci = ~ci;
      e = 0;
      while (!mon_valid && e < 40) begin
         if (e < lat) begin
            chk("add_a_lo", 64'(mon_aa), 64'(a[31:0]));
            chk("add_b_lo", 64'(mon_ab), 64'(b[31:0]));
            chk("add_ci_lo", 64'(mon_aci), 64'(ci));
         end else begin
            chk("add_a_hi", 64'(mon_aa), 64'(a[63:32]));
            chk("add_b_hi", 64'(mon_ab), 64'(b[63:32]));
            chk("add_ci_hi", 64'(mon_aci), 64'(lo[32]));
         end
         chk("busy_ready", 64'(mon_ready), 64'd0);
         chk("busy_sum_hold", mon_sum, prev_sum[idx]);
         chk("busy_flags_hold", 64'({mon_co, mon_ovf}), 64'({prev_co[idx], prev_ovf[idx]}));
         tick();
         e++;
      end
      chk("latency", 64'(e), 64'(2 * lat));
      chk("sum", mon_sum, full[63:0]);
      chk("co", 64'(mon_co), 64'(full[64]));
      chk("ovf", 64'(mon_ovf), 64'(eovf));
      chk("excl", 64'(mon_valid & mon_ready), 64'd0);
      prev_sum[idx] = full[63:0];
      prev_co[idx]  = full[64];
      prev_ovf[idx] = eovf;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("done_valid", 64'(mon_valid), 64'd1);
         chk("done_ready", 64'(mon_ready), 64'd0);
         chk("done_sum", mon_sum, full[63:0]);
      end
      drv_oready = 1'b1;
      tick();
      chk("release_valid", 64'(mon_valid), 64'd0);
      chk("release_ready", 64'(mon_ready), 64'd1);
      chk("release_sum", mon_sum, full[63:0]);
      drv_oready = 1'b0;
      drv_valid  = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_valid"}, 64'(mon_valid), 64'd0);
      chk({tag, "_ready"}, 64'(mon_ready), 64'd0);
      chk({tag, "_sum"}, mon_sum, 64'd0);
      chk({tag, "_flags"}, 64'({mon_co, mon_ovf}), 64'd0);
      chk({tag, "_add"}, {mon_aa, mon_ab}, 64'd0);
      chk({tag, "_add_ci"}, 64'(mon_aci), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; sel = 1'b0; drv_valid = 1'b0; drv_ci = 1'b0; drv_oready = 1'b0;
      drv_a = 64'd0; drv_b = 64'd0;
      for (int i = 0; i < 2; i++) begin
         prev_sum[i] = 64'd0; prev_co[i] = 1'b0; prev_ovf[i] = 1'b0;
      end
      tick();
      tick();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk_cleared("reset");
      end
      rst_n = 1'b1;
      sel   = 1'b0;
      #1;

      do_txn(64'd0, 64'd0, 1'b0, 1);
      do_txn(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 0);
      do_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
      do_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
      do_txn(64'h0000_FFFF_135F_A562, 64'hFFFF_0000_3561_4642, 1'b0, 3);
      do_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         do_txn({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
                int'($urandom_range(2)));
      end

      sel = 1'b1;
      #1;
      do_txn(64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002, 1'b0, 1);
      do_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
      for (int i = 0; i < 8; i++) begin
         do_txn({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
                int'($urandom_range(2)));
      end

      // Abandon a LAT=1 transaction in its high half.
      sel = 1'b0;
      #1;
      drv_a = 64'h1234_5678_9ABC_DEF0; drv_b = 64'h0FED_CBA9_8765_4321; drv_ci = 1'b1;
      drv_valid = 1'b1;
      tick();
      drv_valid = 1'b0;
      tick();
      chk("pre_reset_add_hi", 64'(mon_aa), 64'h0000_0000_1234_5678);
      rst_n = 1'b0;
      #1;
      chk_cleared("async_reset");
      sel = 1'b1;
      #1;
      chk_cleared("async_reset_lat3");
      sel = 1'b0;
      tick();
      chk("reset_no_valid", 64'(mon_valid), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         prev_sum[i] = 64'd0; prev_co[i] = 1'b0; prev_ovf[i] = 1'b0;
      end
      #1;
      do_txn(64'd5, 64'd7, 1'b0, 0);
      sel = 1'b1;
      #1;
      do_txn(64'd5, 64'd7, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
